// File: rtl/router_pkg.sv
// Shared constants, state encodings and helpers for the router write-side controller.
package router_pkg;

    localparam int NUM_PORTS  = 3;
    localparam int DEF_DATA_W = 8;
    localparam int DEF_LEN_W  = 6;

    localparam logic [1:0] ADDR_INVALID = 2'b11;

    // State encodings kept as plain constants so legacy code can compare raw state codes.
    typedef logic [2:0] state_t;

    localparam state_t DECODE_ADDRESS  = 3'd0;
    localparam state_t WAIT_TILL_EMPTY = 3'd1;
    localparam state_t LOAD_FIRST_DATA = 3'd2;
    localparam state_t LOAD_DATA       = 3'd3;
    localparam state_t FIFO_FULL_STATE = 3'd4;
    localparam state_t LOAD_AFTER_FULL = 3'd5;
    localparam state_t LOAD_PARITY     = 3'd6;
    localparam state_t CHECK_PARITY    = 3'd7;

    // One-hot FIFO select; the invalid address selects nothing.
    function automatic logic [NUM_PORTS-1:0] port_sel(input logic [1:0] addr);
        logic [NUM_PORTS-1:0] sel;
        case (addr)
            2'd0:    sel = 3'b001;
            2'd1:    sel = 3'b010;
            2'd2:    sel = 3'b100;
            default: sel = 3'b000;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/router_pkt_ctrl_if.sv
// Source-side byte stream and FIFO-bank signals of the router write path.
interface router_pkt_ctrl_if #(
    parameter int DATA_W = router_pkg::DEF_DATA_W
);
    logic                             pkt_valid;
    logic [DATA_W-1:0]                data_in;
    logic [router_pkg::NUM_PORTS-1:0] fifo_full;
    logic [router_pkg::NUM_PORTS-1:0] fifo_empty;
    logic [router_pkg::NUM_PORTS-1:0] soft_reset;
    logic                             busy;
    logic [router_pkg::NUM_PORTS-1:0] write_enb;
    logic [DATA_W-1:0]                dout;
    logic                             lfd_state;
    logic                             parity_err;
    logic                             pkt_done;

    // Environment side: source, FIFO flags and timeout logic.
    modport master (
        output pkt_valid, data_in, fifo_full, fifo_empty, soft_reset,
        input  busy, write_enb, dout, lfd_state, parity_err, pkt_done
    );

    // Controller side.
    modport slave (
        input  pkt_valid, data_in, fifo_full, fifo_empty, soft_reset,
        output busy, write_enb, dout, lfd_state, parity_err, pkt_done
    );
endinterface

// File: rtl/router_pkt_reg.sv
// Packet datapath: header, held byte, running parity, received parity and payload count.
module router_pkt_reg
    import router_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int LEN_W  = DEF_LEN_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              i_clr,
    input  logic              i_hdr_ld,
    input  logic              i_pay_ld,
    input  logic              i_par_ld,
    input  logic              i_hold_ld,
    input  logic              i_hold_par,
    input  logic [DATA_W-1:0] i_data,
    output logic [DATA_W-1:0] o_header,
    output logic [DATA_W-1:0] o_hold,
    output logic [1:0]        o_addr,
    output logic              o_len_zero,
    output logic              o_last,
    output logic              o_more,
    output logic              o_held_par,
    output logic              o_par_mismatch
);
    logic [DATA_W-1:0] r_header;
    logic [DATA_W-1:0] r_hold;
    logic [DATA_W-1:0] r_parity_acc;
    logic [DATA_W-1:0] r_rx_parity;
    logic [LEN_W-1:0]  r_count;
    logic              r_held_par;
    logic [LEN_W-1:0]  w_len;
    logic [LEN_W-1:0]  w_count_inc;

    assign w_len       = r_header[DATA_W-1 -: LEN_W];
    assign w_count_inc = r_count + LEN_W'(1);

    // Header load restarts the packet; payload bytes fold into parity whether written or held.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_header     <= '0;
            r_hold       <= '0;
            r_parity_acc <= '0;
            r_rx_parity  <= '0;
            r_count      <= '0;
            r_held_par   <= 1'b0;
        end else if (i_hdr_ld) begin
            r_header     <= i_data;
            r_hold       <= '0;
            r_parity_acc <= i_data;
            r_rx_parity  <= '0;
            r_count      <= '0;
            r_held_par   <= 1'b0;
        end else if (i_clr) begin
            r_hold       <= '0;
            r_parity_acc <= '0;
            r_rx_parity  <= '0;
            r_count      <= '0;
            r_held_par   <= 1'b0;
        end else begin
            if (i_pay_ld) begin
                r_parity_acc <= r_parity_acc ^ i_data;
                r_count      <= w_count_inc;
            end
            if (i_par_ld) begin
                r_rx_parity <= i_data;
            end
            if (i_hold_ld) begin
                r_hold     <= i_data;
                r_held_par <= i_hold_par;
            end
        end
    end

    assign o_header       = r_header;
    assign o_hold         = r_hold;
    assign o_addr         = r_header[1:0];
    assign o_len_zero     = (w_len == '0);
    assign o_last         = (w_count_inc == w_len);
    assign o_more         = (r_count < w_len);
    assign o_held_par     = r_held_par;
    assign o_par_mismatch = (r_parity_acc != r_rx_parity);

endmodule

// File: rtl/router_pkt_ctrl.sv
// Write-side packet sequencer: decodes the header, steers bytes into one of three FIFOs,
// stalls the source while the target FIFO is occupied or full, and checks packet parity.
//
// state            | meaning
// DECODE_ADDRESS   | idle, waiting for a header byte
// WAIT_TILL_EMPTY  | target FIFO still holds an older packet
// LOAD_FIRST_DATA  | header written to the FIFO
// LOAD_DATA        | payload bytes written as accepted
// FIFO_FULL_STATE  | accepted byte parked in hold register, FIFO full
// LOAD_AFTER_FULL  | parked byte written once space returns
// LOAD_PARITY      | parity byte written and captured
// CHECK_PARITY     | parity compared, packet completes
module router_pkt_ctrl
    import router_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int LEN_W  = DEF_LEN_W
) (
    input logic              clock,
    input logic              reset,
    router_pkt_ctrl_if.slave bus
);
    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_parity_err;
    logic              r_pkt_done;

    logic [DATA_W-1:0] w_header;
    logic [DATA_W-1:0] w_hold;
    logic [1:0]        w_addr;
    logic              w_len_zero;
    logic              w_last;
    logic              w_more;
    logic              w_held_par;
    logic              w_par_mismatch;
    logic              w_clr;
    logic              w_hdr_ld;
    logic              w_pay_ld;
    logic              w_par_ld;
    logic              w_hold_ld;
    logic              w_hold_par;
    logic              w_full;
    logic              w_srst;

    assign w_full = bus.fifo_full[w_addr];
    assign w_srst = (r_state != DECODE_ADDRESS) && bus.soft_reset[w_addr];

    router_pkt_reg #(
        .DATA_W (DATA_W),
        .LEN_W  (LEN_W)
    ) u_pkt_reg (
        .clock          (clock),
        .reset          (reset),
        .i_clr          (w_clr),
        .i_hdr_ld       (w_hdr_ld),
        .i_pay_ld       (w_pay_ld),
        .i_par_ld       (w_par_ld),
        .i_hold_ld      (w_hold_ld),
        .i_hold_par     (w_hold_par),
        .i_data         (bus.data_in),
        .o_header       (w_header),
        .o_hold         (w_hold),
        .o_addr         (w_addr),
        .o_len_zero     (w_len_zero),
        .o_last         (w_last),
        .o_more         (w_more),
        .o_held_par     (w_held_par),
        .o_par_mismatch (w_par_mismatch)
    );

    // Next state and datapath load strobes; a soft reset on the active port overrides all.
    always_comb begin
        w_state_nxt = r_state;
        w_clr       = 1'b0;
        w_hdr_ld    = 1'b0;
        w_pay_ld    = 1'b0;
        w_par_ld    = 1'b0;
        w_hold_ld   = 1'b0;
        w_hold_par  = 1'b0;
        if (w_srst) begin
            w_state_nxt = DECODE_ADDRESS;
            w_clr       = 1'b1;
        end else begin
            case (r_state)
                DECODE_ADDRESS: begin
                    if (bus.pkt_valid && (bus.data_in[1:0] != ADDR_INVALID)) begin
                        w_hdr_ld    = 1'b1;
                        w_state_nxt = bus.fifo_empty[bus.data_in[1:0]] ? LOAD_FIRST_DATA
                                                                       : WAIT_TILL_EMPTY;
                    end
                end
                WAIT_TILL_EMPTY: begin
                    if (bus.fifo_empty[w_addr]) w_state_nxt = LOAD_FIRST_DATA;
                end
                LOAD_FIRST_DATA: begin
                    w_state_nxt = w_len_zero ? LOAD_PARITY : LOAD_DATA;
                end
                LOAD_DATA: begin
                    if (bus.pkt_valid) begin
                        w_pay_ld = 1'b1;
                        if (w_full) begin
                            w_hold_ld   = 1'b1;
                            w_state_nxt = FIFO_FULL_STATE;
                        end else if (w_last) begin
                            w_state_nxt = LOAD_PARITY;
                        end
                    end
                end
                FIFO_FULL_STATE: begin
                    if (!w_full) w_state_nxt = LOAD_AFTER_FULL;
                end
                LOAD_AFTER_FULL: begin
                    if (w_held_par)  w_state_nxt = CHECK_PARITY;
                    else if (w_more) w_state_nxt = LOAD_DATA;
                    else             w_state_nxt = LOAD_PARITY;
                end
                LOAD_PARITY: begin
                    if (bus.pkt_valid) begin
                        w_par_ld = 1'b1;
                        if (w_full) begin
                            w_hold_ld   = 1'b1;
                            w_hold_par  = 1'b1;
                            w_state_nxt = FIFO_FULL_STATE;
                        end else begin
                            w_state_nxt = CHECK_PARITY;
                        end
                    end
                end
                CHECK_PARITY: begin
                    w_state_nxt = DECODE_ADDRESS;
                end
                default: begin
                    w_state_nxt = DECODE_ADDRESS;
                end
            endcase
        end
    end

    // Moore/data-dependent FIFO-side outputs; writes are suppressed while a port abort is pending.
    always_comb begin
        bus.busy      = 1'b0;
        bus.write_enb = '0;
        bus.dout      = '0;
        bus.lfd_state = 1'b0;
        case (r_state)
            WAIT_TILL_EMPTY, FIFO_FULL_STATE, CHECK_PARITY: begin
                bus.busy = 1'b1;
            end
            LOAD_FIRST_DATA: begin
                bus.busy = 1'b1;
                if (!w_srst) begin
                    bus.write_enb = port_sel(w_addr);
                    bus.dout      = w_header;
                    bus.lfd_state = 1'b1;
                end
            end
            LOAD_DATA, LOAD_PARITY: begin
                if (bus.pkt_valid && !w_full && !w_srst) begin
                    bus.write_enb = port_sel(w_addr);
                    bus.dout      = bus.data_in;
                end
            end
            LOAD_AFTER_FULL: begin
                bus.busy = 1'b1;
                if (!w_srst) begin
                    bus.write_enb = port_sel(w_addr);
                    bus.dout      = w_hold;
                end
            end
            default: begin
            end
        endcase
    end

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) r_state <= DECODE_ADDRESS;
        else       r_state <= w_state_nxt;
    end

    // Completion pulse and sticky parity flag; an aborted packet leaves the flag untouched.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_parity_err <= 1'b0;
            r_pkt_done   <= 1'b0;
        end else begin
            r_pkt_done <= (r_state == CHECK_PARITY) && !w_srst;
            if (w_hdr_ld)
                r_parity_err <= 1'b0;
            else if ((r_state == CHECK_PARITY) && !w_srst)
                r_parity_err <= w_par_mismatch;
        end
    end

    assign bus.parity_err = r_parity_err;
    assign bus.pkt_done   = r_pkt_done;

endmodule

// File: tb/tb_router_pkt_ctrl.sv
// Directed bench for the router write-side packet sequencer.
module tb_router_pkt_ctrl;

    logic clock;
    logic reset;
    int   total;
    int   bad;

    router_pkt_ctrl_if bus ();

    router_pkt_ctrl dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic next_cyc();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [7:0] xor_pkt(input logic [7:0] hdr, input logic [7:0] pay[$]);
        logic [7:0] r;
        r = hdr;
        foreach (pay[i]) r = r ^ pay[i];
        return r;
    endfunction

    // Clean packet: header, optional wait for empty FIFO, payload, parity, completion.
    task automatic send_pkt(input logic [7:0] hdr, input logic [7:0] pay[$],
                            input logic [7:0] par, input int wait_cyc, input logic exp_err);
        logic [2:0] oh;
        int         n;
        oh = 3'b001 << hdr[1:0];
        n  = int'(hdr[7:2]);
        bus.pkt_valid = 1'b1;
        bus.data_in   = hdr;
        if (wait_cyc > 0) bus.fifo_empty[hdr[1:0]] = 1'b0;
        @(negedge clock);
        chk("hdr_busy", bus.busy, 1'b0);
        chk("hdr_we", bus.write_enb, 3'b000);
        next_cyc();
        bus.data_in = (n > 0) ? pay[0] : par;
        for (int i = 0; i < wait_cyc; i++) begin
            if (i == wait_cyc - 1) bus.fifo_empty = 3'b111;
            @(negedge clock);
            chk("wait_busy", bus.busy, 1'b1);
            chk("wait_we", bus.write_enb, 3'b000);
            chk("wait_perr_clr", bus.parity_err, 1'b0);
            next_cyc();
        end
        @(negedge clock);
        chk("lfd_busy", bus.busy, 1'b1);
        chk("lfd_we", bus.write_enb, oh);
        chk("lfd_dout", bus.dout, hdr);
        chk("lfd_flag", bus.lfd_state, 1'b1);
        next_cyc();
        for (int i = 0; i < n; i++) begin
            bus.data_in = pay[i];
            @(negedge clock);
            chk("pay_busy", bus.busy, 1'b0);
            chk("pay_we", bus.write_enb, oh);
            chk("pay_dout", bus.dout, pay[i]);
            chk("pay_lfd", bus.lfd_state, 1'b0);
            next_cyc();
        end
        bus.data_in = par;
        @(negedge clock);
        chk("par_we", bus.write_enb, oh);
        chk("par_dout", bus.dout, par);
        next_cyc();
        bus.pkt_valid = 1'b0;
        bus.data_in   = 8'h00;
        @(negedge clock);
        chk("chk_busy", bus.busy, 1'b1);
        chk("chk_we", bus.write_enb, 3'b000);
        chk("chk_done_early", bus.pkt_done, 1'b0);
        next_cyc();
        @(negedge clock);
        chk("done_pulse", bus.pkt_done, 1'b1);
        chk("done_perr", bus.parity_err, exp_err);
        chk("done_busy", bus.busy, 1'b0);
        next_cyc();
        @(negedge clock);
        chk("done_drop", bus.pkt_done, 1'b0);
        next_cyc();
    endtask

    initial begin
        logic [7:0] p1[$];
        logic [7:0] p3[$];
        logic [7:0] p4[$];
        logic [7:0] p6[$];
        logic [7:0] p7[$];
        logic [7:0] none[$];
        logic [7:0] par;

        total = 0;
        bad   = 0;
        p1 = '{8'h5A, 8'h13, 8'hC7, 8'h2E, 8'h91, 8'h04, 8'hFF,
               8'h68, 8'hB3, 8'h7D, 8'h20, 8'hE9, 8'h46, 8'h8C};
        p3 = '{8'hDE, 8'hAD};
        p4 = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        p6 = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
        p7 = '{8'hC3};

        reset          = 1'b1;
        bus.pkt_valid  = 1'b0;
        bus.data_in    = 8'h00;
        bus.fifo_full  = 3'b000;
        bus.fifo_empty = 3'b111;
        bus.soft_reset = 3'b000;
        next_cyc();
        next_cyc();
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_we", bus.write_enb, 3'b000);
        chk("rst_dout", bus.dout, 8'h00);
        chk("rst_lfd", bus.lfd_state, 1'b0);
        chk("rst_perr", bus.parity_err, 1'b0);
        chk("rst_done", bus.pkt_done, 1'b0);
        reset = 1'b0;
        next_cyc();

        // Good packet to port 1, 14 payload bytes.
        par = xor_pkt(8'h39, p1);
        send_pkt(8'h39, p1, par, 0, 1'b0);

        // Same packet with a corrupted parity byte.
        send_pkt(8'h39, p1, par ^ 8'h01, 0, 1'b1);
        @(negedge clock);
        chk("perr_sticky", bus.parity_err, 1'b1);
        next_cyc();

        // Port 2 occupied at header time; the error flag clears on header acceptance.
        send_pkt(8'h0A, p3, xor_pkt(8'h0A, p3), 3, 1'b0);

        // Port 0 goes full while payload byte 5 is accepted, for three cycles.
        bus.pkt_valid = 1'b1;
        bus.data_in   = 8'h20;
        @(negedge clock);
        chk("f_hdr_busy", bus.busy, 1'b0);
        next_cyc();
        bus.data_in = p4[0];
        @(negedge clock);
        chk("f_lfd_we", bus.write_enb, 3'b001);
        chk("f_lfd_dout", bus.dout, 8'h20);
        next_cyc();
        for (int i = 0; i < 5; i++) begin
            bus.data_in = p4[i];
            @(negedge clock);
            chk("f_pay_we", bus.write_enb, 3'b001);
            chk("f_pay_dout", bus.dout, p4[i]);
            next_cyc();
        end
        bus.data_in   = p4[5];
        bus.fifo_full = 3'b001;
        @(negedge clock);
        chk("f_cap_busy", bus.busy, 1'b0);
        chk("f_cap_we", bus.write_enb, 3'b000);
        next_cyc();
        bus.data_in = p4[6];
        for (int i = 0; i < 2; i++) begin
            @(negedge clock);
            chk("f_full_busy", bus.busy, 1'b1);
            chk("f_full_we", bus.write_enb, 3'b000);
            next_cyc();
        end
        bus.fifo_full = 3'b000;
        @(negedge clock);
        chk("f_rel_busy", bus.busy, 1'b1);
        chk("f_rel_we", bus.write_enb, 3'b000);
        next_cyc();
        @(negedge clock);
        chk("f_laf_busy", bus.busy, 1'b1);
        chk("f_laf_we", bus.write_enb, 3'b001);
        chk("f_laf_dout", bus.dout, p4[5]);
        next_cyc();
        for (int i = 6; i < 8; i++) begin
            bus.data_in = p4[i];
            @(negedge clock);
            chk("f_tail_we", bus.write_enb, 3'b001);
            chk("f_tail_dout", bus.dout, p4[i]);
            next_cyc();
        end
        bus.data_in = xor_pkt(8'h20, p4);
        @(negedge clock);
        chk("f_par_we", bus.write_enb, 3'b001);
        chk("f_par_dout", bus.dout, xor_pkt(8'h20, p4));
        next_cyc();
        bus.pkt_valid = 1'b0;
        @(negedge clock);
        chk("f_chk_busy", bus.busy, 1'b1);
        next_cyc();
        @(negedge clock);
        chk("f_done", bus.pkt_done, 1'b1);
        chk("f_perr", bus.parity_err, 1'b0);
        next_cyc();

        // Invalid address is dropped, then a zero-length packet to port 0.
        bus.pkt_valid = 1'b1;
        bus.data_in   = 8'h03;
        @(negedge clock);
        chk("a3_we", bus.write_enb, 3'b000);
        chk("a3_busy", bus.busy, 1'b0);
        next_cyc();
        @(negedge clock);
        chk("a3_stay_we", bus.write_enb, 3'b000);
        chk("a3_stay_lfd", bus.lfd_state, 1'b0);
        next_cyc();
        send_pkt(8'h00, none, 8'h00, 0, 1'b0);

        // Soft reset: other port ignored, own port aborts back to idle.
        bus.pkt_valid = 1'b1;
        bus.data_in   = 8'h11;
        next_cyc();
        bus.data_in = p6[0];
        next_cyc();
        @(negedge clock);
        chk("s_pay0_we", bus.write_enb, 3'b010);
        next_cyc();
        bus.data_in = p6[1];
        next_cyc();
        bus.pkt_valid  = 1'b0;
        bus.soft_reset = 3'b001;
        @(negedge clock);
        chk("s_other_we", bus.write_enb, 3'b000);
        next_cyc();
        bus.soft_reset = 3'b000;
        bus.pkt_valid  = 1'b1;
        bus.data_in    = p6[2];
        @(negedge clock);
        chk("s_other_cont_we", bus.write_enb, 3'b010);
        chk("s_other_cont_dout", bus.dout, p6[2]);
        next_cyc();
        bus.pkt_valid  = 1'b0;
        bus.soft_reset = 3'b010;
        next_cyc();
        bus.soft_reset = 3'b000;
        @(negedge clock);
        chk("s_idle_busy", bus.busy, 1'b0);
        chk("s_idle_we", bus.write_enb, 3'b000);
        next_cyc();
        @(negedge clock);
        chk("s_no_done", bus.pkt_done, 1'b0);
        next_cyc();
        send_pkt(8'h05, p7, xor_pkt(8'h05, p7), 0, 1'b0);

        // Asynchronous reset while the header is being written.
        bus.pkt_valid = 1'b1;
        bus.data_in   = 8'h39;
        next_cyc();
        bus.data_in = p1[0];
        @(negedge clock);
        chk("r_pre_we", bus.write_enb, 3'b010);
        chk("r_pre_lfd", bus.lfd_state, 1'b1);
        #1 reset = 1'b1;
        #1;
        chk("r_busy", bus.busy, 1'b0);
        chk("r_we", bus.write_enb, 3'b000);
        chk("r_dout", bus.dout, 8'h00);
        chk("r_lfd", bus.lfd_state, 1'b0);
        chk("r_perr", bus.parity_err, 1'b0);
        chk("r_done", bus.pkt_done, 1'b0);
        bus.pkt_valid = 1'b0;
        next_cyc();
        reset = 1'b0;
        @(negedge clock);
        chk("r_after_busy", bus.busy, 1'b0);
        chk("r_after_we", bus.write_enb, 3'b000);
        next_cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
